csr_file: RTL and testbench

Machine-mode CSR responder for the 3-stage RV32I pipeline. It services the csr_reg_wr and csr_reg_rd requests that the decoder raises for SYSTEM-opcode instructions (funct3 != 0). It owns the M-mode trap state, takes timer and external interrupts, executes MRET, and returns a registered redirect PC and flush pulse to the fetch stage. A free-running 64-bit mcycle counter is included.

---
 rtl/csr_file_if.sv | 15 +
 rtl/csr_file.sv | 94 +++++++++
 tb/tb_csr_file.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// csr_file_if: decoder-to-CSR request/response bus.
interface csr_file_if;
    logic        csr_reg_wr;
    logic        csr_reg_rd;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic [31:0] csr_rdata;
    logic        illegal_csr;
    modport master(output csr_reg_wr, csr_reg_rd, funct3, csr_addr, rs1_data, zimm,
                   input csr_rdata, illegal_csr);
    modport slave(input csr_reg_wr, csr_reg_rd, funct3, csr_addr, rs1_data, zimm,
                  output csr_rdata, illegal_csr);
endinterface

// File: rtl/csr_file.sv
// csr_file: M-mode CSRs, interrupt entry, MRET and mcycle for the 3-stage RV32I pipeline.
module csr_file #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    csr_file_if.slave       bus,
    input  logic [XLEN-1:0] pc,
    input  logic            is_mret,
    input  logic            timer_irq,
    input  logic            ext_irq,
    output logic            epc_taken,
    output logic [XLEN-1:0] epc
);
    logic        mie_b, mpie, mtie, meie;
    logic [31:0] mtvec, mepc, mcause;
    logic [63:0] mcycle;
    logic [31:0] cur, op, wdata, cause, vec;
    logic        hit, ro, upd, irq, mret_go, trap_go, wr_go;
    always_comb begin
        hit = 1'b1;
        cur = 32'h0;
        case (bus.csr_addr)
            12'h300: cur = {24'h0, mpie, 3'b000, mie_b, 3'b000};
            12'h304: cur = {20'h0, meie, 3'b000, mtie, 7'h00};
            12'h305: cur = mtvec;
            12'h341: cur = mepc;
            12'h342: cur = mcause;
            12'h344: cur = {20'h0, ext_irq, 3'b000, timer_irq, 7'h00};
            12'hB00: cur = mcycle[31:0];
            12'hB80: cur = mcycle[63:32];
            default: hit = 1'b0;
        endcase
        op = bus.funct3[2] ? {27'h0, bus.zimm} : bus.rs1_data;
        wdata = bus.funct3[1:0] == 2'b01 ? op : bus.funct3[1:0] == 2'b10 ? cur | op : cur & ~op;
        // RS/RC with a zero operand are pure reads and never count as writes
        upd = bus.csr_reg_wr & (bus.funct3[1:0] == 2'b01 | (bus.funct3[1:0] != 2'b00 & op != 32'h0));
        ro = bus.csr_addr == 12'h344;
        bus.illegal_csr = ((bus.csr_reg_rd | bus.csr_reg_wr) & ~hit) | (upd & ro);
        bus.csr_rdata = bus.csr_reg_rd ? cur : 32'h0;
        irq = mie_b & ((ext_irq & meie) | (timer_irq & mtie)) & ~epc_taken;
        mret_go = is_mret & ~epc_taken;
        trap_go = irq & ~mret_go;
        wr_go = upd & hit & ~ro & ~mret_go & ~trap_go;
        cause = (ext_irq & meie) ? 32'h8000_000B : 32'h8000_0007;
        vec = {mtvec[31:2], 2'b00} + (mtvec[1:0] == 2'b01 ? {25'h0, cause[4:0], 2'b00} : 32'h0);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_b     <= 1'b0;
            mpie      <= 1'b0;
            mtie      <= 1'b0;
            meie      <= 1'b0;
            mtvec     <= MTVEC_RST;
            mepc      <= 32'h0;
            mcause    <= 32'h0;
            mcycle    <= 64'h0;
            epc_taken <= 1'b0;
            epc       <= '0;
        end else begin
            epc_taken <= mret_go | trap_go;
            if (mret_go | trap_go) epc <= mret_go ? mepc : vec;
            mcycle <= mcycle + 64'h1;
            if (mret_go) begin
                mie_b <= mpie;
                mpie  <= 1'b1;
            end else if (trap_go) begin
                mepc   <= pc & 32'hFFFF_FFFC;
                mcause <= cause;
                mpie   <= mie_b;
                mie_b  <= 1'b0;
            end else if (wr_go) begin
                case (bus.csr_addr)
                    12'h300: begin
                        mie_b <= wdata[3];
                        mpie  <= wdata[7];
                    end
                    12'h304: begin
                        mtie <= wdata[7];
                        meie <= wdata[11];
                    end
                    12'h305: mtvec <= wdata;
                    12'h341: mepc <= wdata & 32'hFFFF_FFFC;
                    12'h342: mcause <= wdata;
                    // a written half takes the exact value; the counter skips its increment
                    12'hB00: mcycle <= {mcycle[63:32], wdata};
                    12'hB80: mcycle <= {wdata, mcycle[31:0]};
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed scenario tasks for csr_file with hand-computed expectations.
module tb_csr_file;
    logic        clk, rst, is_mret, timer_irq, ext_irq, epc_taken;
    logic [31:0] pc, epc;
    int total, bad;
    csr_file_if bus();
    csr_file #(.MTVEC_RST(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .pc(pc), .is_mret(is_mret),
        .timer_irq(timer_irq), .ext_irq(ext_irq), .epc_taken(epc_taken), .epc(epc)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic do_wr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r, input logic [4:0] z);
        @(negedge clk);
        bus.csr_reg_wr = 1'b1;
        bus.csr_reg_rd = 1'b0;
        bus.funct3 = f3;
        bus.csr_addr = a;
        bus.rs1_data = r;
        bus.zimm = z;
        @(posedge clk);
        #1 bus.csr_reg_wr = 1'b0;
    endtask
    task automatic do_rd(input logic [11:0] a);
        @(negedge clk);
        bus.csr_reg_wr = 1'b0;
        bus.csr_reg_rd = 1'b1;
        bus.csr_addr = a;
        #1;
    endtask
    task automatic test_reset;
        rst = 1'b0;
        bus.csr_reg_wr = 0; bus.csr_reg_rd = 0; bus.funct3 = 0; bus.csr_addr = 0;
        bus.rs1_data = 0; bus.zimm = 0; pc = 0; is_mret = 0; timer_irq = 0; ext_irq = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL reset_epc_taken got=%b exp=0", epc_taken); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", epc); end
        do_rd(12'h300);
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL reset_mstatus got=%h exp=0", bus.csr_rdata); end
        total++; if (bus.illegal_csr !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal_csr); end
        do_rd(12'h304);
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL reset_mie got=%h exp=0", bus.csr_rdata); end
        do_rd(12'h341);
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL reset_mepc got=%h exp=0", bus.csr_rdata); end
    endtask
    task automatic test_vectored_timer;
        do_wr(3'b001, 12'h305, 32'h0000_1001, 5'd0);
        do_wr(3'b010, 12'h304, 32'h0000_0880, 5'd0);
        do_wr(3'b110, 12'h300, 32'h0, 5'd8);
        do_rd(12'h305);
        total++; if (bus.csr_rdata !== 32'h1001) begin bad++; $display("FAIL mtvec_rw got=%h exp=1001", bus.csr_rdata); end
        do_rd(12'h304);
        total++; if (bus.csr_rdata !== 32'h880) begin bad++; $display("FAIL mie_rs got=%h exp=880", bus.csr_rdata); end
        do_rd(12'h300);
        total++; if (bus.csr_rdata !== 32'h8) begin bad++; $display("FAIL mstatus_rsi got=%h exp=8", bus.csr_rdata); end
        @(negedge clk);
        bus.csr_reg_rd = 0; pc = 32'h40; timer_irq = 1;
        @(posedge clk);
        #1 timer_irq = 0;
        total++; if (epc_taken !== 1'b1) begin bad++; $display("FAIL vec_taken got=%b exp=1", epc_taken); end
        total++; if (epc !== 32'h101C) begin bad++; $display("FAIL vec_epc got=%h exp=101c", epc); end
        @(posedge clk);
        #1;
        total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL vec_pulse_len got=%b exp=0", epc_taken); end
        do_rd(12'h341);
        total++; if (bus.csr_rdata !== 32'h40) begin bad++; $display("FAIL vec_mepc got=%h exp=40", bus.csr_rdata); end
        do_rd(12'h342);
        total++; if (bus.csr_rdata !== 32'h8000_0007) begin bad++; $display("FAIL vec_mcause got=%h exp=80000007", bus.csr_rdata); end
        do_rd(12'h300);
        total++; if (bus.csr_rdata !== 32'h80) begin bad++; $display("FAIL vec_mstatus got=%h exp=80", bus.csr_rdata); end
    endtask
    task automatic test_direct_both;
        do_wr(3'b001, 12'h305, 32'h0000_1000, 5'd0);
        do_wr(3'b110, 12'h300, 32'h0, 5'd8);
        @(negedge clk);
        bus.csr_reg_rd = 0; pc = 32'h80; timer_irq = 1; ext_irq = 1;
        @(posedge clk);
        #1 timer_irq = 0; ext_irq = 0;
        total++; if (epc_taken !== 1'b1) begin bad++; $display("FAIL dir_taken got=%b exp=1", epc_taken); end
        total++; if (epc !== 32'h1000) begin bad++; $display("FAIL dir_epc got=%h exp=1000", epc); end
        do_rd(12'h342);
        total++; if (bus.csr_rdata !== 32'h8000_000B) begin bad++; $display("FAIL dir_mcause got=%h exp=8000000b", bus.csr_rdata); end
        do_rd(12'h341);
        total++; if (bus.csr_rdata !== 32'h80) begin bad++; $display("FAIL dir_mepc got=%h exp=80", bus.csr_rdata); end
    endtask
    task automatic test_mret;
        @(negedge clk);
        bus.csr_reg_rd = 0; timer_irq = 1; is_mret = 1; pc = 32'h200;
        @(posedge clk);
        #1 is_mret = 0; pc = 32'h300;
        total++; if (epc_taken !== 1'b1) begin bad++; $display("FAIL mret_taken got=%b exp=1", epc_taken); end
        total++; if (epc !== 32'h80) begin bad++; $display("FAIL mret_epc got=%h exp=80", epc); end
        do_rd(12'h300);
        total++; if (bus.csr_rdata !== 32'h88) begin bad++; $display("FAIL mret_mstatus got=%h exp=88", bus.csr_rdata); end
        @(posedge clk);
        #1;
        total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL mret_blocked got=%b exp=0", epc_taken); end
        @(posedge clk);
        #1 timer_irq = 0;
        total++; if (epc_taken !== 1'b1) begin bad++; $display("FAIL retake_taken got=%b exp=1", epc_taken); end
        total++; if (epc !== 32'h1000) begin bad++; $display("FAIL retake_epc got=%h exp=1000", epc); end
        do_rd(12'h341);
        total++; if (bus.csr_rdata !== 32'h300) begin bad++; $display("FAIL retake_mepc got=%h exp=300", bus.csr_rdata); end
    endtask
    task automatic test_mcycle_illegal;
        do_wr(3'b001, 12'hB80, 32'h12, 5'd0);
        do_wr(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0);
        do_rd(12'hB00);
        total++; if (bus.csr_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mcycle_wr got=%h exp=ffffffff", bus.csr_rdata); end
        bus.csr_addr = 12'hB80;
        #1;
        total++; if (bus.csr_rdata !== 32'h12) begin bad++; $display("FAIL mcycleh_hold got=%h exp=12", bus.csr_rdata); end
        do_rd(12'hB80);
        total++; if (bus.csr_rdata !== 32'h13) begin bad++; $display("FAIL mcycleh_carry got=%h exp=13", bus.csr_rdata); end
        bus.csr_addr = 12'hB00;
        #1;
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL mcycle_wrap got=%h exp=0", bus.csr_rdata); end
        @(negedge clk);
        bus.csr_reg_wr = 1; bus.csr_reg_rd = 1; bus.funct3 = 3'b011; bus.csr_addr = 12'h344; bus.rs1_data = 32'h80;
        #1;
        total++; if (bus.illegal_csr !== 1'b1) begin bad++; $display("FAIL mip_rc_illegal got=%b exp=1", bus.illegal_csr); end
        bus.funct3 = 3'b010; bus.rs1_data = 32'h0;
        #1;
        total++; if (bus.illegal_csr !== 1'b0) begin bad++; $display("FAIL mip_rs0_legal got=%b exp=0", bus.illegal_csr); end
        bus.csr_reg_wr = 0; ext_irq = 1;
        #1;
        total++; if (bus.csr_rdata !== 32'h800) begin bad++; $display("FAIL mip_read got=%h exp=800", bus.csr_rdata); end
        ext_irq = 0;
        do_rd(12'h7C0);
        total++; if (bus.illegal_csr !== 1'b1) begin bad++; $display("FAIL bad_addr_illegal got=%b exp=1", bus.illegal_csr); end
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL bad_addr_rdata got=%h exp=0", bus.csr_rdata); end
    endtask
    task automatic test_async_reset;
        do_wr(3'b110, 12'h300, 32'h0, 5'd8);
        @(negedge clk);
        bus.csr_reg_rd = 1; bus.csr_addr = 12'h300; timer_irq = 1; pc = 32'h500;
        #2 rst = 0;
        #1;
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL arst_epc got=%h exp=0", epc); end
        total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL arst_taken got=%b exp=0", epc_taken); end
        total++; if (bus.csr_rdata !== 32'h0) begin bad++; $display("FAIL arst_mstatus got=%h exp=0", bus.csr_rdata); end
        @(negedge clk);
        rst = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
            total++; if (epc_taken !== 1'b0) begin bad++; $display("FAIL arst_no_pulse got=%b exp=0", epc_taken); end
        end
        timer_irq = 0;
    endtask
    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_vectored_timer;
        test_direct_both;
        test_mret;
        test_mcycle_illegal;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
